// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus bundle: two requesting masters on one side, three slaves on the other.
// The arbiter connects through 'master' (it masters the slave bus); the surrounding system uses 'slave'.
interface mem_bus_arbiter_if;
  logic [31:0] m0_address;
  logic [31:0] m1_address;
  logic        m0_rw_req;
  logic        m1_rw_req;
  logic        m0_rw;
  logic        m1_rw;
  logic [31:0] m0_write_data;
  logic [31:0] m1_write_data;
  logic [1:0]  m0_size;
  logic [1:0]  m1_size;
  logic [31:0] m0_read_data;
  logic [31:0] m1_read_data;
  logic        m0_rec;
  logic        m1_rec;
  logic        m0_err;
  logic        m1_err;

  logic [31:0] s_address;
  logic        s_rw;
  logic [31:0] s_write_data;
  logic [1:0]  s_size;
  logic        s_mem_rw_req;
  logic        s_dram_rw_req;
  logic        s_per_rw_req;
  logic [31:0] s_mem_read_data;
  logic [31:0] s_dram_read_data;
  logic [31:0] s_per_read_data;
  logic        s_mem_valid;
  logic        s_dram_valid;
  logic        s_per_valid;

  modport master (
    input  m0_address, m1_address, m0_rw_req, m1_rw_req, m0_rw, m1_rw,
           m0_write_data, m1_write_data, m0_size, m1_size,
           s_mem_read_data, s_dram_read_data, s_per_read_data,
           s_mem_valid, s_dram_valid, s_per_valid,
    output m0_read_data, m1_read_data, m0_rec, m1_rec, m0_err, m1_err,
           s_address, s_rw, s_write_data, s_size,
           s_mem_rw_req, s_dram_rw_req, s_per_rw_req
  );

  modport slave (
    output m0_address, m1_address, m0_rw_req, m1_rw_req, m0_rw, m1_rw,
           m0_write_data, m1_write_data, m0_size, m1_size,
           s_mem_read_data, s_dram_read_data, s_per_read_data,
           s_mem_valid, s_dram_valid, s_per_valid,
    input  m0_read_data, m1_read_data, m0_rec, m1_rec, m0_err, m1_err,
           s_address, s_rw, s_write_data, s_size,
           s_mem_rw_req, s_dram_rw_req, s_per_rw_req
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the CPU memory bus with address decode to mem/dram/per
// slaves and a per-transaction timeout so a dead slave cannot hang the bus.
module mem_bus_arbiter #(
  parameter logic [31:0] BRAM_TOP = 32'h0001_0000,
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              mclk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus,
  output logic              busy
);
  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RELEASE} state_e;
  typedef enum logic [1:0] {SEL_MEM, SEL_DRAM, SEL_PER} sel_e;

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d, sel_c;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      s_addr_q, s_addr_d;
  logic [31:0]      s_wdata_q, s_wdata_d;
  logic             s_rw_q, s_rw_d;
  logic [1:0]       s_size_q, s_size_d;
  logic [2:0]       s_req_q, s_req_d;
  logic [31:0]      rd0_q, rd0_d, rd1_q, rd1_d;
  logic [1:0]       rec_q, rec_d, err_q, err_d;
  logic             busy_q, busy_d;

  logic             req_any_c, grant_c, valid_c, timeout_c;
  logic [31:0]      gaddr_c, sdata_c;

  assign req_any_c = bus.m0_rw_req | bus.m1_rw_req;
  // On a tie the master that did not win last time is granted.
  assign grant_c   = (bus.m0_rw_req & bus.m1_rw_req) ? ~last_q : bus.m1_rw_req;
  assign gaddr_c   = grant_c ? bus.m1_address : bus.m0_address;
  assign timeout_c = (cnt_q == CNT_LAST);

  // Slave decode of the address being granted.
  always_comb begin
    sel_c = SEL_DRAM;
    if (gaddr_c[31])              sel_c = SEL_PER;
    else if (gaddr_c < BRAM_TOP)  sel_c = SEL_MEM;
  end

  // Only the decoded slave's completion and data are observed.
  always_comb begin
    valid_c = 1'b0;
    sdata_c = '0;
    case (sel_q)
      SEL_MEM:  begin valid_c = bus.s_mem_valid;  sdata_c = bus.s_mem_read_data;  end
      SEL_DRAM: begin valid_c = bus.s_dram_valid; sdata_c = bus.s_dram_read_data; end
      SEL_PER:  begin valid_c = bus.s_per_valid;  sdata_c = bus.s_per_read_data;  end
      default:  ;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_any_c) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (valid_c | timeout_c) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d     = sel_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_rw_d    = s_rw_q;
    s_size_d  = s_size_q;
    s_req_d   = s_req_q;
    rd0_d     = '0;
    rd1_d     = '0;
    rec_d     = 2'b00;
    err_d     = 2'b00;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req_any_c) begin
          owner_d   = grant_c;
          last_d    = grant_c;
          sel_d     = sel_c;
          cnt_d     = '0;
          s_addr_d  = gaddr_c;
          s_wdata_d = grant_c ? bus.m1_write_data : bus.m0_write_data;
          s_rw_d    = grant_c ? bus.m1_rw : bus.m0_rw;
          s_size_d  = grant_c ? bus.m1_size : bus.m0_size;
          case (sel_c)
            SEL_MEM:  s_req_d = 3'b001;
            SEL_DRAM: s_req_d = 3'b010;
            SEL_PER:  s_req_d = 3'b100;
            default:  s_req_d = 3'b000;
          endcase
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A valid on the timeout cycle still completes normally.
        if (valid_c | timeout_c) begin
          s_req_d         = 3'b000;
          rec_d[owner_q]  = 1'b1;
          err_d[owner_q]  = ~valid_c;
          if (owner_q) rd1_d = valid_c ? sdata_c : ERR_DATA;
          else         rd0_d = valid_c ? sdata_c : ERR_DATA;
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        s_req_d = 3'b000;
      end
      default: s_req_d = 3'b000;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      sel_q     <= SEL_MEM;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_rw_q    <= 1'b0;
      s_size_q  <= '0;
      s_req_q   <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rec_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_rw_q    <= s_rw_d;
      s_size_q  <= s_size_d;
      s_req_q   <= s_req_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      rec_q     <= rec_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_address     = s_addr_q;
  assign bus.s_write_data  = s_wdata_q;
  assign bus.s_rw          = s_rw_q;
  assign bus.s_size        = s_size_q;
  assign bus.s_mem_rw_req  = s_req_q[0];
  assign bus.s_dram_rw_req = s_req_q[1];
  assign bus.s_per_rw_req  = s_req_q[2];
  assign bus.m0_read_data  = rd0_q;
  assign bus.m1_read_data  = rd1_q;
  assign bus.m0_rec        = rec_q[0];
  assign bus.m1_rec        = rec_q[1];
  assign bus.m0_err        = err_q[0];
  assign bus.m1_err        = err_q[1];
  assign busy              = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of arbitration, decode and timeout.
module tb_mem_bus_arbiter;
  localparam int unsigned TMO = 8;

  logic mclk  = 1'b0;
  logic reset = 1'b1;
  logic busy;
  always #5 mclk = ~mclk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [2:0] sreq_vec();
    return {bus.s_per_rw_req, bus.s_dram_rw_req, bus.s_mem_rw_req};
  endfunction

  // ---------------- reference model: one open transaction at a time ----------------
  logic [1:0]  exp_rec, exp_err;
  logic [31:0] exp_rd [2];
  logic [2:0]  exp_sreq;
  logic [31:0] exp_saddr, exp_swd;
  logic        exp_srw, exp_busy;
  logic [1:0]  exp_ssize;
  bit          model_ok = 1'b0;
  int          owner = -1, last = 1, sel = 0, waited = 0;
  bit          cooling = 1'b0;
  logic        sv [3];
  logic [31:0] sd [3];

  function automatic int decode(input logic [31:0] a);
    if (a >= 32'h8000_0000) return 2;
    if (a < 32'h0001_0000)  return 0;
    return 1;
  endfunction

  always @(posedge mclk) begin : model
    exp_rec   = 2'b00;
    exp_err   = 2'b00;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    sv[0] = bus.s_mem_valid;  sd[0] = bus.s_mem_read_data;
    sv[1] = bus.s_dram_valid; sd[1] = bus.s_dram_read_data;
    sv[2] = bus.s_per_valid;  sd[2] = bus.s_per_read_data;
    if (reset) begin
      owner = -1; last = 1; cooling = 1'b0;
      exp_sreq = '0; exp_saddr = '0; exp_swd = '0; exp_srw = 1'b0; exp_ssize = '0;
      exp_busy = 1'b0; model_ok = 1'b1;
    end else if (cooling) begin
      cooling  = 1'b0;
      exp_busy = 1'b0;
    end else if (owner < 0) begin
      if (bus.m0_rw_req || bus.m1_rw_req) begin
        if (bus.m0_rw_req && bus.m1_rw_req) owner = 1 - last;
        else                                owner = bus.m0_rw_req ? 0 : 1;
        last      = owner;
        exp_saddr = (owner == 0) ? bus.m0_address : bus.m1_address;
        exp_swd   = (owner == 0) ? bus.m0_write_data : bus.m1_write_data;
        exp_srw   = (owner == 0) ? bus.m0_rw : bus.m1_rw;
        exp_ssize = (owner == 0) ? bus.m0_size : bus.m1_size;
        sel       = decode(exp_saddr);
        exp_sreq  = 3'(1 << sel);
        waited    = 0;
        exp_busy  = 1'b1;
      end
    end else begin
      waited++;
      if (sv[sel]) begin
        exp_rec[owner] = 1'b1;
        exp_rd[owner]  = sd[sel];
      end else if (waited == TMO) begin
        exp_rec[owner] = 1'b1;
        exp_err[owner] = 1'b1;
        exp_rd[owner]  = 32'hDEADBEEF;
      end
      if (exp_rec != 2'b00) begin
        exp_sreq = '0;
        owner    = -1;
        cooling  = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge mclk) begin
    if (model_ok) begin
      chk("m0_rec",   32'(bus.m0_rec),  32'(exp_rec[0]));
      chk("m1_rec",   32'(bus.m1_rec),  32'(exp_rec[1]));
      chk("m0_err",   32'(bus.m0_err),  32'(exp_err[0]));
      chk("m1_err",   32'(bus.m1_err),  32'(exp_err[1]));
      chk("m0_rdata", bus.m0_read_data, exp_rd[0]);
      chk("m1_rdata", bus.m1_read_data, exp_rd[1]);
      chk("s_req",    32'(sreq_vec()),  32'(exp_sreq));
      chk("s_addr",   bus.s_address,    exp_saddr);
      chk("s_wdata",  bus.s_write_data, exp_swd);
      chk("s_rw",     32'(bus.s_rw),    32'(exp_srw));
      chk("s_size",   32'(bus.s_size),  32'(exp_ssize));
      chk("busy",     32'(busy),        32'(exp_busy));
      chk("s_req_onehot", 32'($countones(sreq_vec()) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge mclk);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(6))
      0:       return $urandom_range(32'h0000_FFFF);
      1:       return 32'h0000_FFFF;
      2:       return 32'h0001_0000;
      3:       return 32'h0001_0000 + $urandom_range(32'h7FFE_FFFF);
      4:       return 32'h7FFF_FFFF;
      5:       return 32'h8000_0000;
      default: return 32'h8000_0000 | $urandom;
    endcase
  endfunction

  task automatic new_fields(output logic [31:0] a, output logic w,
                            output logic [31:0] d, output logic [1:0] s);
    a = rnd_addr();
    w = 1'($urandom_range(1));
    d = $urandom;
    s = 2'($urandom_range(2));
  endtask

  logic [31:0] baddr [4] = '{32'h0000_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [2:0]  bsel  [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
  logic [31:0] bdata [4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0022, 32'h0000_0033};
  int          got [$];

  initial begin
    int n;
    bus.m0_address = '0; bus.m1_address = '0; bus.m0_rw_req = 1'b0; bus.m1_rw_req = 1'b0;
    bus.m0_rw = 1'b0; bus.m1_rw = 1'b0; bus.m0_write_data = '0; bus.m1_write_data = '0;
    bus.m0_size = '0; bus.m1_size = '0;
    bus.s_mem_read_data = '0; bus.s_dram_read_data = '0; bus.s_per_read_data = '0;
    bus.s_mem_valid = 1'b0; bus.s_dram_valid = 1'b0; bus.s_per_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req",  32'(sreq_vec()), 32'd0);
    chk("rst_addr", bus.s_address, 32'd0);
    reset = 1'b0;
    tick();

    // m0 read from on-chip memory, slave answers after three cycles
    bus.m0_address = 32'h0000_0100; bus.m0_rw = 1'b0; bus.m0_size = 2'd2; bus.m0_rw_req = 1'b1;
    tick();
    chk("t1_req", 32'(sreq_vec()), 32'b001);
    repeat (3) tick();
    bus.s_mem_valid = 1'b1; bus.s_mem_read_data = 32'h1234_5678;
    tick();
    chk("t1_rec",   32'(bus.m0_rec), 32'd1);
    chk("t1_rdata", bus.m0_read_data, 32'h1234_5678);
    chk("t1_m1",    32'(bus.m1_rec) | bus.m1_read_data, 32'd0);
    chk("t1_busy",  32'(busy), 32'd1);
    bus.m0_rw_req = 1'b0; bus.s_mem_valid = 1'b0;
    tick();
    chk("t1_idle",  32'(busy), 32'd0);

    // Decode boundaries, every slave claims valid but only the decoded one is used
    bus.s_mem_read_data = 32'h11; bus.s_dram_read_data = 32'h22; bus.s_per_read_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      bus.m0_address = baddr[i]; bus.m0_rw_req = 1'b1;
      tick();
      chk("dec_req", 32'(sreq_vec()), 32'(bsel[i]));
      bus.s_mem_valid = 1'b1; bus.s_dram_valid = 1'b1; bus.s_per_valid = 1'b1;
      tick();
      chk("dec_rdata", bus.m0_read_data, bdata[i]);
      bus.m0_rw_req = 1'b0; bus.s_mem_valid = 1'b0; bus.s_dram_valid = 1'b0; bus.s_per_valid = 1'b0;
      tick();
    end

    // m1 write to a dead peripheral times out
    bus.m1_address = 32'h8000_0004; bus.m1_rw = 1'b1; bus.m1_write_data = 32'hCAFE_F00D;
    bus.m1_size = 2'd2; bus.m1_rw_req = 1'b1;
    bus.s_mem_valid = 1'b1; bus.s_dram_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.m1_rec) break;
      if (bus.s_per_rw_req) n++;
    end
    chk("to_cycles", 32'(n), 32'd8);
    chk("to_rec",    32'(bus.m1_rec), 32'd1);
    chk("to_err",    32'(bus.m1_err), 32'd1);
    chk("to_rdata",  bus.m1_read_data, 32'hDEAD_BEEF);
    chk("to_wdata",  bus.s_write_data, 32'hCAFE_F00D);
    chk("to_req",    32'(sreq_vec()), 32'd0);
    bus.m1_rw_req = 1'b0; bus.s_mem_valid = 1'b0; bus.s_dram_valid = 1'b0;
    tick();

    // dram valid arrives on the last allowed cycle
    bus.m0_address = 32'h0002_0000; bus.m0_rw = 1'b0; bus.m0_rw_req = 1'b1;
    tick();
    chk("edge_req", 32'(sreq_vec()), 32'b010);
    repeat (7) tick();
    bus.s_dram_valid = 1'b1; bus.s_dram_read_data = 32'hA5A5_0001;
    tick();
    chk("edge_rec",   32'(bus.m0_rec), 32'd1);
    chk("edge_err",   32'(bus.m0_err), 32'd0);
    chk("edge_rdata", bus.m0_read_data, 32'hA5A5_0001);
    bus.m0_rw_req = 1'b0; bus.s_dram_valid = 1'b0;
    tick();

    // Reset two cycles into a dram transaction, then simultaneous requests
    bus.m0_rw_req = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_req",  32'(sreq_vec()), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rec",  32'(bus.m0_rec), 32'd0);
    reset = 1'b0;
    bus.m1_address = 32'h0000_0200; bus.m1_rw = 1'b0; bus.m1_rw_req = 1'b1;
    tick();
    chk("tie_first", bus.s_address, 32'h0002_0000);
    bus.s_mem_valid = 1'b1; bus.s_dram_valid = 1'b1;
    for (int k = 0; k < 40 && got.size() < 4; k++) begin
      tick();
      if (bus.m0_rec) got.push_back(0);
      if (bus.m1_rec) got.push_back(1);
    end
    chk("rr_count", 32'(got.size()), 32'd4);
    foreach (got[k]) chk("rr_order", 32'(got[k]), 32'(k % 2));
    bus.m0_rw_req = 1'b0; bus.m1_rw_req = 1'b0; bus.s_mem_valid = 1'b0; bus.s_dram_valid = 1'b0;
    repeat (2) tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.m0_rw_req && bus.m0_rec) begin
        bus.m0_rw_req = 1'($urandom_range(1));
        new_fields(bus.m0_address, bus.m0_rw, bus.m0_write_data, bus.m0_size);
      end else if (!bus.m0_rw_req && $urandom_range(3) == 0) begin
        bus.m0_rw_req = 1'b1;
        new_fields(bus.m0_address, bus.m0_rw, bus.m0_write_data, bus.m0_size);
      end else if (bus.m0_rw_req && $urandom_range(199) == 0) begin
        bus.m0_rw_req = 1'b0;
      end
      if (bus.m1_rw_req && bus.m1_rec) begin
        bus.m1_rw_req = 1'($urandom_range(1));
        new_fields(bus.m1_address, bus.m1_rw, bus.m1_write_data, bus.m1_size);
      end else if (!bus.m1_rw_req && $urandom_range(3) == 0) begin
        bus.m1_rw_req = 1'b1;
        new_fields(bus.m1_address, bus.m1_rw, bus.m1_write_data, bus.m1_size);
      end else if (bus.m1_rw_req && $urandom_range(199) == 0) begin
        bus.m1_rw_req = 1'b0;
      end
      bus.s_mem_valid  = ($urandom_range(3) == 0);
      bus.s_dram_valid = ($urandom_range(4) == 0);
      bus.s_per_valid  = ($urandom_range(5) == 0);
      bus.s_mem_read_data  = $urandom;
      bus.s_dram_read_data = $urandom;
      bus.s_per_read_data  = $urandom;
      reset = ($urandom_range(399) == 0);
    end
    reset = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
